load_ext_ctrl: RTL

LOAD_EXT_CTRL -- requirements
Module: load_ext_ctrl

---
 rtl/load_ext_pkg.sv | 42 ++++
 rtl/load_lane_ext.sv | 39 +++
 rtl/load_ext_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/load_ext_pkg.sv
// Package for the load extension controller.
// Holds the load opcode encodings, the controller FSM state type,
// the default wait timeout and small opcode-classification helpers.
// Optional feature macro used by the controller: MISALIGN_TRAP_EN.
package load_ext_pkg;

  // Load opcode low bits as they arrive on req_op.
  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEF = 16;

  // True for the five load opcodes the controller executes.
  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // True when the low address bits do not match the access size.
  function automatic logic op_is_misaligned(input logic [2:0] op,
                                            input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU: return lo[0];
      OP_LW:         return |lo;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_lane_ext.sv
// Combinational lane select and extension for a load result.
// Ports:
//   rdata  - 32-bit memory word (little-endian lanes)
//   addr   - low two bits of the byte address
//   op     - load opcode (LB/LH/LW/LBU/LHU); other codes give 0
//   result - extended 32-bit load result
// Halfword selection uses addr[1] only, so an odd halfword address
// reads the halfword that contains it.
module load_lane_ext
  import load_ext_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];
    byte_s   = signed'(byte_sel);
    half_s   = signed'(half_sel);
    result   = 32'd0;
    case (op)
      OP_LB:   result = unsigned'(32'(byte_s));
      OP_LH:   result = unsigned'(32'(half_s));
      OP_LW:   result = rdata;
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LHU:  result = {16'd0, half_sel};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_ext_ctrl.sv
// Load controller: accepts one load request at a time, performs a single
// word read from data memory, extends the addressed lane and returns the
// result with an error flag.
// Ports:
//   CLK, RST             - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake (ready only when idle)
//   req_addr, req_op     - byte address and load opcode
//   mem_req, mem_addr    - read strobe and word-aligned address
//   mem_ack, mem_rdata   - read completion and data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_data, rsp_err    - extended result and failure flag
// Parameter TIMEOUT_CYC: WAIT cycles allowed before the load is aborted.
// Macro MISALIGN_TRAP_EN: when defined, misaligned LH/LHU/LW fail without
// a memory access; when undefined, the offending low bits are ignored.
module load_ext_ctrl
  import load_ext_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_op,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [1:0]       lane_q;
  logic [31:0]      ext_data;
  logic             misalign;
  logic             go_wait;
  logic             go_trap;
  logic             ack_hit;
  logic             timeout;

`ifdef MISALIGN_TRAP_EN
  assign misalign = op_is_misaligned(req_op, req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    go_wait   = 1'b0;
    go_trap   = 1'b0;
    ack_hit   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!op_is_legal(req_op) || misalign) begin
            go_trap   = 1'b1;
            state_nxt = RESP;
          end else begin
            go_wait   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        // An ack in the last allowed cycle wins over the timeout.
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter, read address and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      mem_addr <= 32'd0;
      rsp_data <= 32'd0;
      rsp_err  <= 1'b0;
    end else begin
      if (go_wait) begin
        cnt      <= '0;
        mem_addr <= {req_addr[31:2], 2'b00};
      end else if (state == WAIT && !mem_ack && !timeout) begin
        cnt <= cnt + 1'b1;
      end

      if (go_trap || timeout) begin
        rsp_data <= 32'd0;
        rsp_err  <= 1'b1;
      end else if (ack_hit) begin
        rsp_data <= ext_data;
        rsp_err  <= 1'b0;
      end
    end
  end

  // Captured request fields feeding the lane extender during WAIT
  always_ff @(posedge CLK) begin
    if (go_wait) begin
      op_q   <= req_op;
      lane_q <= req_addr[1:0];
    end
  end

  load_lane_ext u_lane_ext (
    .rdata  (mem_rdata),
    .addr   (lane_q),
    .op     (op_q),
    .result (ext_data)
  );

endmodule
